la_rrarb5: RTL and testbench

LA_RRARB5 -- requirements
Module: la_rrarb5

---
 rtl/la_rrarb_pkg.sv | 42 ++++
 rtl/la_rrarb5_pick.sv | 22 ++
 rtl/la_rrarb5.sv | 130 +++++++++++++
 tb/tb_la_rrarb5.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/la_rrarb_pkg.sv
// Shared arbiter definitions: requester count, pointer width, lock state
// and the one-hot/index helpers used by the 5-way round-robin arbiter.
package la_rrarb_pkg;

  localparam int NREQ  = 5;
  localparam int PTR_W = 3;

  typedef logic [NREQ-1:0]  req_t;
  typedef logic [PTR_W-1:0] ptr_t;

  // Packet lock state (only meaningful when LA_RRARB5_LOCK_EN is defined)
  typedef enum logic {
    LK_IDLE = 1'b0,
    LK_HELD = 1'b1
  } lock_e;

  function automatic req_t onehot(input ptr_t i);
    req_t r;
    r = '0;
    for (int k = 0; k < NREQ; k++)
      if (i == ptr_t'(k)) r[k] = 1'b1;
    return r;
  endfunction

  // Index of the set bit in a one-hot vector (0 when none set)
  function automatic ptr_t oh2idx(input req_t oh);
    ptr_t r;
    r = '0;
    for (int k = 0; k < NREQ; k++)
      if (oh[k]) r = ptr_t'(k);
    return r;
  endfunction

  // Successor pointer, wrapping NREQ-1 -> 0
  function automatic ptr_t ptr_next(input ptr_t i);
    ptr_t r;
    if (i >= ptr_t'(NREQ - 1)) r = '0;
    else                       r = i + ptr_t'(1);
    return r;
  endfunction

endpackage

// File: rtl/la_rrarb5_pick.sv
// Combinational rotate-and-priority pick: first valid requester found when
// searching upward from ptr_i, wrapping past the top requester to 0.
module la_rrarb5_pick
  import la_rrarb_pkg::*;
(
  input  logic [NREQ-1:0]  valid_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  pick_o
);

  // Walk the requesters in rotated order, keeping only the first hit
  always_comb begin
    pick_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (j < NREQ && pick_o == '0 && valid_i[j]) pick_o[j] = 1'b1;
    end
  end

endmodule

// File: rtl/la_rrarb5.sv
// 5-requester round-robin arbiter with a single registered output stage.
// Optional packet lock compiled in with LA_RRARB5_LOCK_EN: once a requester
// starts a packet it keeps the grant until it sends its last beat.
module la_rrarb5
  import la_rrarb_pkg::*;
#(
  parameter int N    = 1,
  parameter     PROP = "DEFAULT"
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] valid,
  input  logic [NREQ-1:0] last,
  input  logic [N-1:0]    in4,
  input  logic [N-1:0]    in3,
  input  logic [N-1:0]    in2,
  input  logic [N-1:0]    in1,
  input  logic [N-1:0]    in0,
  output logic [NREQ-1:0] ready,
  output logic [N-1:0]    out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NREQ-1:0] sel
);

  logic [NREQ-1:0][N-1:0] in_arr;
  req_t                   pick, cand, sel_q, sel_d;
  ptr_t                   ptr_q, ptr_d;
  logic [N-1:0]           out_q, out_d, data_mux;
  logic                   vld_q, vld_d;
  logic                   stage_free, xfer, adv;
  logic                   unused_prop;

  // Cell property string is carried for the library flow only
  assign unused_prop = (PROP == "DEFAULT");

  assign in_arr     = {in4, in3, in2, in1, in0};
  assign stage_free = ~vld_q | out_ready;

  la_rrarb5_pick u_pick (
    .valid_i (valid),
    .ptr_i   (ptr_q),
    .pick_o  (pick)
  );

`ifdef LA_RRARB5_LOCK_EN
  lock_e lock_q;
  req_t  lock_oh_q;
  logic  last_beat;

  // While a packet is open only its owner may be granted; if it drops
  // valid the grant simply stalls and the lock stays put.
  assign cand      = (lock_q == LK_HELD) ? (valid & lock_oh_q) : pick;
  assign last_beat = |(ready & last);
  assign adv       = xfer & last_beat;

  // Open the lock on a non-final beat, close it on the final one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q    <= LK_IDLE;
      lock_oh_q <= '0;
    end else if (xfer) begin
      if (last_beat) begin
        lock_q <= LK_IDLE;
      end else begin
        lock_q    <= LK_HELD;
        lock_oh_q <= ready;
      end
    end
  end
`else
  logic unused_last;

  assign unused_last = ^last;
  assign cand        = pick;
  assign adv         = xfer;
`endif

  // Grant only into a free stage; nothing is granted while in reset
  always_comb begin
    ready = '0;
    if (stage_free && !reset) ready = cand;
  end

  assign xfer = |ready;

  // One-hot AND-OR select using the grant that is about to be registered
  always_comb begin
    data_mux = '0;
    for (int i = 0; i < NREQ; i++)
      data_mux = data_mux | (in_arr[i] & {N{ready[i]}});
  end

  // Next state of the output stage and the round-robin pointer
  always_comb begin
    out_d = out_q;
    sel_d = sel_q;
    vld_d = vld_q;
    ptr_d = ptr_q;
    if (xfer) begin
      out_d = data_mux;
      sel_d = ready;
      vld_d = 1'b1;
    end else if (out_ready) begin
      sel_d = '0;
      vld_d = 1'b0;
    end
    if (adv) ptr_d = ptr_next(oh2idx(ready));
  end

  // Output stage and pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
      sel_q <= '0;
      vld_q <= 1'b0;
      ptr_q <= '0;
    end else begin
      out_q <= out_d;
      sel_q <= sel_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
    end
  end

  assign out       = out_q;
  assign sel       = sel_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_la_rrarb5.sv
// Scoreboard bench for la_rrarb5 (N=8). Stimulus pushes the expected beat
// for every hand-predicted grant; a negedge monitor pops and compares each
// beat the DUT hands downstream.
module tb_la_rrarb5;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [4:0]   valid, last, ready, sel;
  logic [N-1:0] in0, in1, in2, in3, in4, out;
  logic         out_valid, out_ready;

  typedef struct packed {
    logic [4:0]   sel;
    logic [N-1:0] data;
  } beat_t;

  beat_t expq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    gseq[5];

  la_rrarb5 #(.N(N), .PROP("DEFAULT")) dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .last      (last),
    .in4       (in4),
    .in3       (in3),
    .in2       (in2),
    .in1       (in1),
    .in0       (in0),
    .ready     (ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] oh(input int g);
    logic [4:0] r;
    r = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [N-1:0] dat(input int g);
    return 8'hA0 + 8'(g);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted output beat must match the head of the queue
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got sel %b out %h expected no beat", sel, out);
      end else begin
        beat_t e;
        e = expq.pop_front();
        chk("beat_sel", 32'(sel), 32'(e.sel));
        chk("beat_data", 32'(out), 32'(e.data));
      end
    end
  end

  // One cycle: drive, check ready at negedge, queue the predicted beat
  task automatic step(input logic [4:0] v, input logic [4:0] l, input logic ordy,
                      input int g, input string nm);
    valid     = v;
    last      = l;
    out_ready = ordy;
    @(negedge clk);
    if (g >= 0) begin
      chk({nm, "_ready"}, 32'(ready), 32'(oh(g)));
      expq.push_back('{sel: oh(g), data: dat(g)});
    end else begin
      chk({nm, "_ready"}, 32'(ready), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; valid = 5'b11111; last = 5'b11111; out_ready = 1'b1;
    in0 = dat(0); in1 = dat(1); in2 = dat(2); in3 = dat(3); in4 = dat(4);

    // Reset state with all requesters asking
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Full request, steady drain: 0,1,2,3,4,0
    step(5'b11111, 5'b11111, 1'b1, 0, "rr0");
    step(5'b11111, 5'b11111, 1'b1, 1, "rr1");
    step(5'b11111, 5'b11111, 1'b1, 2, "rr2");
    step(5'b11111, 5'b11111, 1'b1, 3, "rr3");
    step(5'b11111, 5'b11111, 1'b1, 4, "rr4");
    step(5'b11111, 5'b11111, 1'b1, 0, "rr5");

    // Sparse requesters 2 and 4 (ptr=1): 2,4,2
    step(5'b10100, 5'b11111, 1'b1, 2, "sp0");
    step(5'b10100, 5'b11111, 1'b1, 4, "sp1");
    step(5'b10100, 5'b11111, 1'b1, 2, "sp2");
    step(5'b00000, 5'b11111, 1'b1, -1, "idle0");

    // Single beat from 1, then backpressure for 3 cycles
    step(5'b00010, 5'b11111, 1'b1, 1, "single");
    for (int c = 0; c < 3; c++) begin
      valid = 5'b11111; out_ready = 1'b0;
      @(negedge clk);
      chk("stall_ready", 32'(ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_sel", 32'(sel), 32'b00010);
      chk("stall_out", 32'(out), 32'(dat(1)));
      @(posedge clk); #1;
    end
    step(5'b00000, 5'b11111, 1'b1, -1, "accept");
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_sel", 32'(sel), 32'd0);
    chk("drain_out_hold", 32'(out), 32'(dat(1)));

    // Mid-stream reset (ptr=2): beat 2 delivered, beat 3 discarded
    step(5'b11111, 5'b11111, 1'b1, 2, "mid0");
    valid = 5'b11111; out_ready = 1'b1;
    @(negedge clk);
    chk("mid1_ready", 32'(ready), 32'(oh(3)));
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_sel", 32'(sel), 32'd0);
    chk("mrst_out", 32'(out), 32'd0);
    chk("mrst_ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(5'b11111, 5'b11111, 1'b1, 0, "post0");
    step(5'b11111, 5'b11111, 1'b1, 1, "post1");
    step(5'b00000, 5'b11111, 1'b1, -1, "idle1");

    // Requester 3 sends a 3-beat packet while 0 and 4 compete
`ifdef LA_RRARB5_LOCK_EN
    gseq = '{3, 3, 3, 4, 0};
`else
    gseq = '{3, 4, 0, 3, 4};
`endif
    step(5'b01000, 5'b00000, 1'b1, gseq[0], "pk0");
    step(5'b11001, 5'b00000, 1'b1, gseq[1], "pk1");
    step(5'b11001, 5'b01000, 1'b1, gseq[2], "pk2");
    step(5'b11001, 5'b11111, 1'b1, gseq[3], "pk3");
    step(5'b11001, 5'b11111, 1'b1, gseq[4], "pk4");
    step(5'b00000, 5'b11111, 1'b1, -1, "idle2");
    step(5'b00000, 5'b11111, 1'b1, -1, "idle3");

    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
